// File: rtl/ascon_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pkg
// Shared definitions for the ASCON substitution layer:
//   - state and word widths
//   - FSM state encoding of the serial substitution engine
//   - the 32-entry 5-bit S-box table (reference copy of the substitution)
// ---------------------------------------------------------------------------
package ascon_pkg;

    localparam int ASCON_WORD_W  = 64;
    localparam int ASCON_STATE_W = 320;
    localparam int SBOX_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    localparam logic [SBOX_W-1:0] SBOX_TABLE [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

endpackage

// File: rtl/ascon_sub_layer_sboxtable.sv
// ---------------------------------------------------------------------------
// sboxtable
// Purely combinational 5-bit ASCON S-box lookup.
// Ports:
//   sbox_i  5-bit column {x0,x1,x2,x3,x4}, x0 in the MSB
//   sbox_o  substituted 5-bit column, same bit order
// ---------------------------------------------------------------------------
module sboxtable
    import ascon_pkg::*;
(
    input  logic [SBOX_W-1:0] sbox_i,
    output logic [SBOX_W-1:0] sbox_o
);

    always_comb begin
        sbox_o = '0;
        case (sbox_i)
            5'h00: sbox_o = 5'h04;
            5'h01: sbox_o = 5'h0B;
            5'h02: sbox_o = 5'h1F;
            5'h03: sbox_o = 5'h14;
            5'h04: sbox_o = 5'h1A;
            5'h05: sbox_o = 5'h15;
            5'h06: sbox_o = 5'h09;
            5'h07: sbox_o = 5'h02;
            5'h08: sbox_o = 5'h1B;
            5'h09: sbox_o = 5'h05;
            5'h0A: sbox_o = 5'h08;
            5'h0B: sbox_o = 5'h12;
            5'h0C: sbox_o = 5'h1D;
            5'h0D: sbox_o = 5'h03;
            5'h0E: sbox_o = 5'h06;
            5'h0F: sbox_o = 5'h1C;
            5'h10: sbox_o = 5'h1E;
            5'h11: sbox_o = 5'h13;
            5'h12: sbox_o = 5'h07;
            5'h13: sbox_o = 5'h0E;
            5'h14: sbox_o = 5'h00;
            5'h15: sbox_o = 5'h0D;
            5'h16: sbox_o = 5'h11;
            5'h17: sbox_o = 5'h18;
            5'h18: sbox_o = 5'h10;
            5'h19: sbox_o = 5'h0C;
            5'h1A: sbox_o = 5'h01;
            5'h1B: sbox_o = 5'h19;
            5'h1C: sbox_o = 5'h16;
            5'h1D: sbox_o = 5'h0A;
            5'h1E: sbox_o = 5'h0F;
            5'h1F: sbox_o = 5'h17;
        endcase
    end

endmodule

// File: rtl/ascon_sub_layer.sv
// ---------------------------------------------------------------------------
// ascon_sub_layer
// Serial ASCON substitution layer. A 320-bit state (five 64-bit words) is
// captured, its 64 bit-sliced columns are pushed through LANES S-boxes per
// cycle, and the substituted state is presented on the output side.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input state handshake, x0_in..x4_in state words
//   out_valid / out_ready output state handshake, x0_out..x4_out words
//   busy                  high while columns are being substituted (RUN)
//   state_dbg             current FSM state encoding (sub_state_e)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised, holds with stable data until that edge;
// ready is decoded from registered state only, never from the input valid.
// ---------------------------------------------------------------------------
module ascon_sub_layer
    import ascon_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x0_in,
    input  logic [63:0] x1_in,
    input  logic [63:0] x2_in,
    input  logic [63:0] x3_in,
    input  logic [63:0] x4_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] x0_out,
    output logic [63:0] x1_out,
    output logic [63:0] x2_out,
    output logic [63:0] x3_out,
    output logic [63:0] x4_out,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int N  = ASCON_WORD_W / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
        $error("ascon_sub_layer: LANES must be a power of two in 1..64");
    end

    sub_state_e                     state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    // x_q[0] holds word x0, x_q[4] holds word x4
    logic [4:0][ASCON_WORD_W-1:0]   x_q, x_d;

    logic [LANES-1:0][SBOX_W-1:0]   sb_in;
    logic [LANES-1:0][SBOX_W-1:0]   sb_out;
    // S-box results regrouped per word: ins_bits[w][j] is word w of column j
    logic [4:0][LANES-1:0]          ins_bits;

    // The lowest LANES columns are always the next ones to substitute;
    // results re-enter at the top so after N shifts every bit is home.
    for (genvar j = 0; j < LANES; j++) begin : g_sbox
        assign sb_in[j] = {x_q[0][j], x_q[1][j], x_q[2][j], x_q[3][j], x_q[4][j]};
        sboxtable u_sbox (
            .sbox_i (sb_in[j]),
            .sbox_o (sb_out[j])
        );
    end

    always_comb begin
        ins_bits = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int w = 0; w < 5; w++) begin
                ins_bits[w][j] = sb_out[j][4-w];
            end
        end
    end

    // State register together with the counter and working registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    x_d[0]  = x0_in;
                    x_d[1]  = x1_in;
                    x_d[2]  = x2_in;
                    x_d[3]  = x3_in;
                    x_d[4]  = x4_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int w = 0; w < 5; w++) begin
                    x_d[w] = (x_q[w] >> LANES) |
                             (64'(ins_bits[w]) << (ASCON_WORD_W - LANES));
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN);
        state_dbg = state_q;
    end

    assign x0_out = x_q[0];
    assign x1_out = x_q[1];
    assign x2_out = x_q[2];
    assign x3_out = x_q[3];
    assign x4_out = x_q[4];

endmodule

// File: tb/tb_ascon_sub_layer.sv
// ---------------------------------------------------------------------------
// tb_ascon_sub_layer
// Bench for ascon_sub_layer with LANES=1 (dut1) and LANES=8 (dut8).
// State vectors are packed as {x0, x1, x2, x3, x4}, x0 in bits [319:256].
// Inputs are changed and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ascon_sub_layer;

    localparam logic [4:0] TBL [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };
    localparam int W = 320;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic         in_valid1, out_ready1, in_valid8, out_ready8;
    logic [W-1:0] din1, din8;
    wire          in_ready1, out_valid1, busy1, in_ready8, out_valid8, busy8;
    wire  [W-1:0] dout1, dout8;
    wire  [1:0]   state1, state8;

    ascon_sub_layer #(.LANES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .x0_in     (din1[319:256]),
        .x1_in     (din1[255:192]),
        .x2_in     (din1[191:128]),
        .x3_in     (din1[127:64]),
        .x4_in     (din1[63:0]),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .x0_out    (dout1[319:256]),
        .x1_out    (dout1[255:192]),
        .x2_out    (dout1[191:128]),
        .x3_out    (dout1[127:64]),
        .x4_out    (dout1[63:0]),
        .busy      (busy1),
        .state_dbg (state1)
    );

    ascon_sub_layer #(.LANES(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .x0_in     (din8[319:256]),
        .x1_in     (din8[255:192]),
        .x2_in     (din8[191:128]),
        .x3_in     (din8[127:64]),
        .x4_in     (din8[63:0]),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .x0_out    (dout8[319:256]),
        .x1_out    (dout8[255:192]),
        .x2_out    (dout8[191:128]),
        .x3_out    (dout8[127:64]),
        .x4_out    (dout8[63:0]),
        .busy      (busy8),
        .state_dbg (state8)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [4:0] col(input logic [W-1:0] s, input int i);
        return {s[256+i], s[192+i], s[128+i], s[64+i], s[i]};
    endfunction

    function automatic logic [W-1:0] sub_model(input logic [W-1:0] s);
        logic [W-1:0] r;
        logic [4:0]   c;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            c = TBL[col(s, i)];
            r[256+i] = c[4];
            r[192+i] = c[3];
            r[128+i] = c[2];
            r[64+i]  = c[1];
            r[i]     = c[0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [W-1:0] s;
        for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    // ---------------- driver tasks (dut1) ----------------
    // Called at a falling edge; returns at the falling edge after the
    // accepting rising edge, reporting that edge number in e.
    task automatic send1(input logic [W-1:0] s, output int e);
        int t;
        t = 0;
        din1      = s;
        in_valid1 = 1'b1;
        while (!in_ready1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL send1_accept: in_ready=%b after %0d cycles, expected 1", in_ready1, t);
        end
        e = cyc + 1;
        exp_q.push_back(sub_model(s));
        @(negedge clk);
        in_valid1 = 1'b0;
    endtask

    task automatic recv1(input int e, input bit chk_lat, input string name,
                         output logic [W-1:0] got);
        int t;
        logic [W-1:0] exp;
        t = 0;
        while (!out_valid1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (chk_lat) begin
            checks++;
            if (!out_valid1 || (cyc - e) != 64) begin
                errors++;
                $display("FAIL %s_latency: out_valid=%b latency=%0d, expected 1 and 64",
                         name, out_valid1, cyc - e);
            end
        end
        got = dout1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_data: output with empty expected queue, got %h", name, dout1);
        end else begin
            exp = exp_q.pop_front();
            if (dout1 !== exp) begin
                errors++;
                $display("FAIL %s_data: got %h expected %h", name, dout1, exp);
            end
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b, expected 0 1",
                     name, out_valid1, in_ready1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit ok;
        rst_n     = 1'b0;
        in_valid1 = 1'b1;
        in_valid8 = 1'b1;
        din1      = rand_state();
        din8      = rand_state();
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready1, out_valid1, busy1, state1} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/vld/busy/state=%b%b%b/%0d, expected 100/0",
                     in_ready1, out_valid1, busy1, state1);
        end
        checks++;
        if (dout1 !== '0 || dout8 !== '0) begin
            errors++;
            $display("FAIL reset_data: dout1=%h dout8=%h, expected 0", dout1, dout8);
        end
        rst_n     = 1'b1;
        in_valid1 = 1'b0;
        in_valid8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready1, busy1, in_ready8, busy8} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_ignore_valid: rdy1/busy1/rdy8/busy8=%b%b%b%b, expected 1010",
                     in_ready1, busy1, in_ready8, busy8);
        end
        ok = 1'b1;
        for (int i = 0; i < 32; i++) if (ascon_pkg::SBOX_TABLE[i] !== TBL[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pkg_table: package S-box table differs, got ok=%b expected 1", ok);
        end
    endtask

    task automatic test_zero();
        int e;
        logic [W-1:0] got;
        send1('0, e);
        checks++;
        if (busy1 !== 1'b1 || in_ready1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_run: busy=%b in_ready=%b, expected 1 0", busy1, in_ready1);
        end
        recv1(e, 1'b1, "zero", got);
        checks++;
        if (got !== {64'h0, 64'h0, {64{1'b1}}, 64'h0, 64'h0}) begin
            errors++;
            $display("FAIL zero_words: got %h expected x2 all ones, rest 0", got);
        end
    endtask

    task automatic test_ramp();
        int e;
        logic [W-1:0] s, got;
        logic [4:0] c;
        s = '0;
        for (int i = 0; i < 64; i++) begin
            c = 5'(i % 32);
            {s[256+i], s[192+i], s[128+i], s[64+i], s[i]} = c;
        end
        send1(s, e);
        recv1(e, 1'b1, "ramp", got);
        checks++;
        if (col(got, 11) !== 5'h12) begin
            errors++;
            $display("FAIL ramp_0x0b: got %h expected 12", col(got, 11));
        end
        checks++;
        if (col(got, 57) !== 5'h0C) begin
            errors++;
            $display("FAIL ramp_0x19: got %h expected 0c", col(got, 57));
        end
    endtask

    task automatic test_lanes8();
        logic [W-1:0] s, exp;
        int e, t;
        for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? {W{1'b1}} : rand_state();
            exp = sub_model(s);
            din8      = s;
            in_valid8 = 1'b1;
            t = 0;
            while (!in_ready8 && t < 50) begin
                @(negedge clk);
                t++;
            end
            e = cyc + 1;
            @(negedge clk);
            in_valid8 = 1'b0;
            t = 0;
            while (!out_valid8 && t < 50) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (!out_valid8 || (cyc - e) != 8) begin
                errors++;
                $display("FAIL l8_latency_%0d: out_valid=%b latency=%0d, expected 1 and 8",
                         k, out_valid8, cyc - e);
            end
            checks++;
            if (dout8 !== exp) begin
                errors++;
                $display("FAIL l8_data_%0d: got %h expected %h", k, dout8, exp);
            end
            if (k == 0) begin
                checks++;
                if (dout8 !== {{64{1'b1}}, 64'h0, {192{1'b1}}}) begin
                    errors++;
                    $display("FAIL l8_ones: got %h expected x1=0, rest all ones", dout8);
                end
            end
            out_ready8 = 1'b1;
            @(negedge clk);
            out_ready8 = 1'b0;
            checks++;
            if (out_valid8 !== 1'b0) begin
                errors++;
                $display("FAIL l8_release_%0d: out_valid=%b expected 0", k, out_valid8);
            end
        end
    endtask

    task automatic test_backpressure();
        int e, t;
        logic [W-1:0] snap, got;
        bit seen;
        send1(rand_state(), e);
        t = 0;
        while (!out_valid1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        snap = dout1;
        for (int i = 0; i < 10; i++) begin
            in_valid1 = ~in_valid1;
            din1      = rand_state();
            @(negedge clk);
            checks++;
            if ({out_valid1, in_ready1, dout1} !== {1'b1, 1'b0, snap}) begin
                errors++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b data=%h, expected 1 0 %h",
                         i, out_valid1, in_ready1, dout1, snap);
            end
        end
        in_valid1 = 1'b0;
        recv1(e, 1'b0, "bp", got);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid1 || state1 != 2'd0) seen = 1'b1;
        end
        checks++;
        if (seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_single: extra activity=%b queue=%0d, expected 0 0", seen, exp_q.size());
        end
    endtask

    task automatic test_reset_midop();
        int e;
        logic [W-1:0] got;
        bit seen;
        send1(rand_state(), e);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({out_valid1, in_ready1, busy1} !== 3'b010 || dout1 !== '0) begin
            errors++;
            $display("FAIL rst_mid: vld/rdy/busy=%b%b%b data=%h, expected 010 and 0",
                     out_valid1, in_ready1, busy1, dout1);
        end
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_mid_abort: out_valid seen=%b, expected 0", seen);
        end
        exp_q.delete();
        send1(rand_state(), e);
        recv1(e, 1'b1, "rst_next", got);
    endtask

    task automatic test_stream();
        logic [W-1:0] st [4];
        int acc [4];
        logic [W-1:0] exp;
        int idx, got;
        bit pend;
        for (int k = 0; k < 4; k++) st[k] = rand_state();
        idx = 0;
        got = 0;
        pend = 1'b0;
        out_ready1 = 1'b1;
        din1       = st[0];
        in_valid1  = 1'b1;
        for (int c = 0; c < 400 && got < 4; c++) begin
            if (pend) begin
                pend = 1'b0;
                if (idx < 4) din1 = st[idx];
                else in_valid1 = 1'b0;
            end
            if (out_valid1) begin
                checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (dout1 !== exp) begin
                    errors++;
                    $display("FAIL stream_data_%0d: got %h expected %h", got, dout1, exp);
                end
                got++;
            end
            if (in_valid1 && in_ready1) begin
                acc[idx] = cyc + 1;
                exp_q.push_back(sub_model(st[idx]));
                idx++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        out_ready1 = 1'b0;
        in_valid1  = 1'b0;
        checks++;
        if (got != 4 || idx != 4) begin
            errors++;
            $display("FAIL stream_count: outputs=%0d accepts=%0d, expected 4 4", got, idx);
        end
        for (int k = 1; k < 4 && k < idx; k++) begin
            checks++;
            if (acc[k] - acc[k-1] != 66) begin
                errors++;
                $display("FAIL stream_spacing_%0d: got %0d expected 66", k, acc[k] - acc[k-1]);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid1  = 1'b0;
        in_valid8  = 1'b0;
        out_ready1 = 1'b0;
        out_ready8 = 1'b0;
        din1       = '0;
        din8       = '0;
        @(negedge clk);
        test_reset();
        test_zero();
        test_ramp();
        test_lanes8();
        test_backpressure();
        test_reset_midop();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
